// File: rtl/deser_link_ctrl.sv
// Deserializer link bring-up: reset pulse, MMCM/IDELAYCTRL/data-lock waits, frame-clock check, retry/fail.
// Optional error counter in LINKED enabled by defining DESER_ERR_CNT_EN.
module deser_link_ctrl #(
    parameter logic [6:0] CLK_PATT_1   = 7'b1100001,
    parameter logic [6:0] CLK_PATT_2   = 7'b1100011,
    parameter int         RST_PULSE    = 8,
    parameter int         LOCK_TIMEOUT = 1000,
    parameter int         GOOD_WORDS   = 16,
    parameter int         MAX_RETRY    = 3,
    parameter int         BAD_WORDS    = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mmcm_lock,
    input  logic        idelay_rdy,
    input  logic        dat_lock,
    input  logic [6:0]  clk_dat,
    input  logic        restart,
    output logic        deser_reset,
    output logic        idelay_rst,
    output logic        link_up,
    output logic        link_fail,
    output logic [2:0]  state,
    output logic [3:0]  retry_cnt,
    output logic [15:0] err_cnt
);
    typedef enum logic [2:0] {
        S_RESET     = 3'd0,
        S_WAIT_MMCM = 3'd1,
        S_WAIT_IDLY = 3'd2,
        S_WAIT_LOCK = 3'd3,
        S_CHECK     = 3'd4,
        S_LINKED    = 3'd5,
        S_FAIL      = 3'd6
    } state_t;

    state_t      st_q, st_d;
    logic        mmcm_lock_m, idelay_rdy_m, dat_lock_m;
    logic        mmcm_lock_s, idelay_rdy_s, dat_lock_s;
    logic [7:0]  rst_cnt, good_cnt, bad_cnt;
    logic [19:0] to_cnt;
    logic        legal, timeout, in_wait, do_retry;
    logic [4:0]  retry_inc;

    assign legal     = (clk_dat == CLK_PATT_1) || (clk_dat == CLK_PATT_2);
    assign timeout   = (to_cnt == 20'(LOCK_TIMEOUT - 1));
    assign in_wait   = (st_q == S_WAIT_MMCM) || (st_q == S_WAIT_IDLY) ||
                       (st_q == S_WAIT_LOCK) || (st_q == S_CHECK);
    assign retry_inc = {1'b0, retry_cnt} + 5'd1;

    always_comb begin
        st_d     = st_q;
        do_retry = 1'b0;
        case (st_q)
            S_RESET:     if (rst_cnt == 8'(RST_PULSE - 1)) st_d = S_WAIT_MMCM;
            S_WAIT_MMCM: if (timeout) do_retry = 1'b1; else if (mmcm_lock_s) st_d = S_WAIT_IDLY;
            S_WAIT_IDLY: if (timeout) do_retry = 1'b1; else if (idelay_rdy_s) st_d = S_WAIT_LOCK;
            S_WAIT_LOCK: if (timeout) do_retry = 1'b1; else if (dat_lock_s) st_d = S_CHECK;
            // Timeout / lock loss outrank the final good word.
            S_CHECK: begin
                if (timeout || !dat_lock_s)
                    do_retry = 1'b1;
                else if (legal && good_cnt == 8'(GOOD_WORDS - 1))
                    st_d = S_LINKED;
            end
            S_LINKED: begin
                if (!mmcm_lock_s || !dat_lock_s || (!legal && bad_cnt == 8'(BAD_WORDS - 1)))
                    st_d = S_RESET;
            end
            S_FAIL:  st_d = S_FAIL;
            default: st_d = S_RESET;
        endcase
        if (do_retry)
            st_d = (retry_inc == 5'(MAX_RETRY)) ? S_FAIL : S_RESET;
        if (restart) begin
            st_d     = S_RESET;
            do_retry = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            st_q         <= S_RESET;
            mmcm_lock_m  <= 1'b0;
            mmcm_lock_s  <= 1'b0;
            idelay_rdy_m <= 1'b0;
            idelay_rdy_s <= 1'b0;
            dat_lock_m   <= 1'b0;
            dat_lock_s   <= 1'b0;
            rst_cnt      <= '0;
            to_cnt       <= '0;
            good_cnt     <= '0;
            bad_cnt      <= '0;
            retry_cnt    <= '0;
        end else begin
            mmcm_lock_m  <= mmcm_lock;
            mmcm_lock_s  <= mmcm_lock_m;
            idelay_rdy_m <= idelay_rdy;
            idelay_rdy_s <= idelay_rdy_m;
            dat_lock_m   <= dat_lock;
            dat_lock_s   <= dat_lock_m;
            st_q         <= st_d;
            if (restart) begin
                rst_cnt   <= '0;
                to_cnt    <= '0;
                good_cnt  <= '0;
                bad_cnt   <= '0;
                retry_cnt <= '0;
            end else begin
                // Counters restart from zero whenever the state changes.
                rst_cnt  <= (st_q == S_RESET && st_d == S_RESET) ? rst_cnt + 8'd1 : '0;
                to_cnt   <= (in_wait && st_d == st_q) ? to_cnt + 20'd1 : '0;
                good_cnt <= (st_q == S_CHECK && st_d == S_CHECK && legal) ? good_cnt + 8'd1 : '0;
                bad_cnt  <= (st_q == S_LINKED && st_d == S_LINKED && !legal) ? bad_cnt + 8'd1 : '0;
                if (do_retry)
                    retry_cnt <= (retry_cnt == 4'hF) ? retry_cnt : retry_cnt + 4'd1;
                else if (st_d == S_LINKED && st_q != S_LINKED)
                    retry_cnt <= '0;
            end
        end
    end

`ifdef DESER_ERR_CNT_EN
    // Kept across link drops so software can see cumulative damage.
    always_ff @(posedge clk) begin
        if (!resetn || restart)
            err_cnt <= '0;
        else if (st_q == S_LINKED && !legal && err_cnt != 16'hFFFF)
            err_cnt <= err_cnt + 16'd1;
    end
`else
    assign err_cnt = '0;
`endif

    assign state       = st_q;
    assign deser_reset = (st_q == S_RESET) || (st_q == S_FAIL);
    assign idelay_rst  = (st_q == S_RESET) || (st_q == S_WAIT_MMCM);
    assign link_up     = (st_q == S_LINKED);
    assign link_fail   = (st_q == S_FAIL);

endmodule

// File: tb/tb_deser_link_ctrl.sv
// Table-driven bench for deser_link_ctrl (default parameters); expected err_cnt follows DESER_ERR_CNT_EN.
module tb_deser_link_ctrl;
    localparam logic [6:0] P1   = 7'b1100001;
    localparam logic [6:0] P2   = 7'b1100011;
    localparam logic [6:0] BADW = 7'h00;
    localparam logic [3:0] F_DR = 4'b1000, F_IR = 4'b0100, F_LU = 4'b0010, F_LF = 4'b0001;
`ifdef DESER_ERR_CNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b0, mmcm_lock = 1'b0, idelay_rdy = 1'b0, dat_lock = 1'b0, restart = 1'b0;
    logic [6:0]  clk_dat = P1;
    logic        deser_reset, idelay_rst, link_up, link_fail;
    logic [2:0]  state;
    logic [3:0]  retry_cnt;
    logic [15:0] err_cnt;

    // Inputs applied for cyc edges; expected outputs after the last edge. fl = {dr, ir, lu, lf}.
    typedef struct {
        int          cyc;
        logic        rstn, rs, mm, id, dl;
        logic [6:0]  dat;
        logic [2:0]  st;
        logic [3:0]  fl;
        logic [3:0]  rc;
        logic [15:0] err;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   checks = 0, errors = 0;

    always #5 clk = ~clk;

    deser_link_ctrl dut (
        .clk(clk), .resetn(resetn), .mmcm_lock(mmcm_lock), .idelay_rdy(idelay_rdy),
        .dat_lock(dat_lock), .clk_dat(clk_dat), .restart(restart),
        .deser_reset(deser_reset), .idelay_rst(idelay_rst), .link_up(link_up),
        .link_fail(link_fail), .state(state), .retry_cnt(retry_cnt), .err_cnt(err_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic add(input int cyc, input logic rstn, rs, mm, id, dl, input logic [6:0] dat,
                       input logic [2:0] st, input logic [3:0] fl, rc, input logic [15:0] err);
        vec_t v;
        v.cyc = cyc; v.rstn = rstn; v.rs = rs; v.mm = mm; v.id = id; v.dl = dl;
        v.dat = dat; v.st = st; v.fl = fl; v.rc = rc; v.err = err;
        tbl.push_back(v);
    endtask

    // From the cycle RESET was (re)entered with all locks high and a steady legal word.
    task automatic add_bringup(input logic [6:0] dat, input logic [15:0] err);
        add(7,  1, 0, 1, 1, 1, dat, 3'd0, F_DR | F_IR, 4'd0, err);
        add(1,  1, 0, 1, 1, 1, dat, 3'd1, F_IR,        4'd0, err);
        add(1,  1, 0, 1, 1, 1, dat, 3'd2, 4'b0000,     4'd0, err);
        add(1,  1, 0, 1, 1, 1, dat, 3'd3, 4'b0000,     4'd0, err);
        add(1,  1, 0, 1, 1, 1, dat, 3'd4, 4'b0000,     4'd0, err);
        add(15, 1, 0, 1, 1, 1, dat, 3'd4, 4'b0000,     4'd0, err);
        add(1,  1, 0, 1, 1, 1, dat, 3'd5, F_LU,        4'd0, err);
    endtask

    task automatic apply(input vec_t v, input int id);
        vec_t e;
        resetn = v.rstn; restart = v.rs; mmcm_lock = v.mm; idelay_rdy = v.id;
        dat_lock = v.dl; clk_dat = v.dat;
        exp_q.push_back(v);
        repeat (v.cyc) tick();
        e = exp_q.pop_front();
        chk($sformatf("v%0d_state", id), int'(state), int'(e.st));
        chk($sformatf("v%0d_dr_lu_lf", id), int'({deser_reset, link_up, link_fail}),
            int'({e.fl[3], e.fl[1], e.fl[0]}));
        if (e.st != 3'd6)
            chk($sformatf("v%0d_idelay_rst", id), int'(idelay_rst), int'(e.fl[2]));
        chk($sformatf("v%0d_retry_cnt", id), int'(retry_cnt), int'(e.rc));
        chk($sformatf("v%0d_err_cnt", id), int'(err_cnt), ERR_EN ? int'(e.err) : 0);
    endtask

    task automatic run(input int lo, input int hi);
        for (int i = lo; i < hi; i++) apply(tbl[i], i);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, b;
        bit bad;
        // Power-on reset, then clean bring-up.
        add(2, 0, 0, 1, 1, 1, P1, 3'd0, F_DR | F_IR, 4'd0, 16'd0);
        add_bringup(P1, 16'd0);
        // LINKED: 3 bad words held, legal (pattern 2) clears, 4 bad drops the link.
        add(3, 1, 0, 1, 1, 1, BADW, 3'd5, F_LU,        4'd0, 16'd3);
        add(1, 1, 0, 1, 1, 1, P2,   3'd5, F_LU,        4'd0, 16'd3);
        add(3, 1, 0, 1, 1, 1, BADW, 3'd5, F_LU,        4'd0, 16'd6);
        add(1, 1, 0, 1, 1, 1, BADW, 3'd0, F_DR | F_IR, 4'd0, 16'd7);
        add_bringup(P2, 16'd7);
        // One-cycle resetn mid-LINKED, full bring-up repeats.
        add(1, 0, 0, 1, 1, 1, P1, 3'd0, F_DR | F_IR, 4'd0, 16'd0);
        add_bringup(P1, 16'd0);
        // mmcm_lock stuck low: two retries then FAIL, held until restart.
        add(1,   0, 0, 0, 1, 1, P1, 3'd0, F_DR | F_IR, 4'd0, 16'd0);
        for (int r = 0; r < 3; r++) begin
            add(7,   1, 0, 0, 1, 1, P1, 3'd0, F_DR | F_IR, 4'(r), 16'd0);
            add(1,   1, 0, 0, 1, 1, P1, 3'd1, F_IR,        4'(r), 16'd0);
            add(999, 1, 0, 0, 1, 1, P1, 3'd1, F_IR,        4'(r), 16'd0);
            if (r < 2) add(1, 1, 0, 0, 1, 1, P1, 3'd0, F_DR | F_IR, 4'(r + 1), 16'd0);
        end
        add(1, 1, 0, 0, 1, 1, P1, 3'd6, F_DR | F_LF, 4'd3, 16'd0);
        add(5, 1, 0, 0, 1, 1, P1, 3'd6, F_DR | F_LF, 4'd3, 16'd0);
        add(1, 1, 1, 0, 1, 1, P1, 3'd0, F_DR | F_IR, 4'd0, 16'd0);
        // Restart on the same edge as a WAIT_LOCK timeout.
        add(7,   1, 0, 1, 1, 0, P1, 3'd0, F_DR | F_IR, 4'd0, 16'd0);
        add(1,   1, 0, 1, 1, 0, P1, 3'd1, F_IR,        4'd0, 16'd0);
        add(1,   1, 0, 1, 1, 0, P1, 3'd2, 4'b0000,     4'd0, 16'd0);
        add(1,   1, 0, 1, 1, 0, P1, 3'd3, 4'b0000,     4'd0, 16'd0);
        add(999, 1, 0, 1, 1, 0, P1, 3'd3, 4'b0000,     4'd0, 16'd0);
        add(1,   1, 1, 1, 1, 0, P1, 3'd0, F_DR | F_IR, 4'd0, 16'd0);
        // Walk back into CHECK.
        add(7, 1, 0, 1, 1, 1, P1, 3'd0, F_DR | F_IR, 4'd0, 16'd0);
        add(1, 1, 0, 1, 1, 1, P1, 3'd1, F_IR,        4'd0, 16'd0);
        add(1, 1, 0, 1, 1, 1, P1, 3'd2, 4'b0000,     4'd0, 16'd0);
        add(1, 1, 0, 1, 1, 1, P1, 3'd3, 4'b0000,     4'd0, 16'd0);
        add(1, 1, 0, 1, 1, 1, P1, 3'd4, 4'b0000,     4'd0, 16'd0);
        a = tbl.size();
        // 1000th CHECK edge of the 15-good/1-bad loop -> timeout retry, then back to CHECK.
        add(1, 1, 0, 1, 1, 1, P1, 3'd0, F_DR | F_IR, 4'd1, 16'd0);
        add(7, 1, 0, 1, 1, 1, P1, 3'd0, F_DR | F_IR, 4'd1, 16'd0);
        add(1, 1, 0, 1, 1, 1, P1, 3'd1, F_IR,        4'd1, 16'd0);
        add(1, 1, 0, 1, 1, 1, P1, 3'd2, 4'b0000,     4'd1, 16'd0);
        add(1, 1, 0, 1, 1, 1, P1, 3'd3, 4'b0000,     4'd1, 16'd0);
        add(1, 1, 0, 1, 1, 1, P1, 3'd4, 4'b0000,     4'd1, 16'd0);
        b = tbl.size();
        // 16th good word lands on the timeout edge: retry wins.
        add(1, 1, 0, 1, 1, 1, P1, 3'd0, F_DR | F_IR, 4'd2, 16'd0);

        run(0, a);

        bad = 1'b0;
        for (int k = 0; k < 999; k++) begin
            clk_dat = (k % 16 == 15) ? BADW : P1;
            tick();
            if (link_up || state != 3'd4) bad = 1'b1;
        end
        chk("alt15_stays_check", int'(bad), 0);
        run(a, b);

        bad = 1'b0;
        for (int k = 0; k < 999; k++) begin
            clk_dat = (k >= 984) ? P1 : BADW;
            tick();
            if (link_up || state != 3'd4) bad = 1'b1;
        end
        chk("late_good_stays_check", int'(bad), 0);
        run(b, tbl.size());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
